// File: rtl/aes_dec_pkg.sv
// Shared FSM type, round constants and GF(2^8) helpers for the iterative AES-128 decryptor.
// Byte 0 of every 128-bit state/key is bits [127:120]; bytes fill the state column by column.
package aes_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KEXP  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [3:0] AES_NR = 4'd10;

    // Round constants for rounds 1..10; other indices never occur in a running block.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    // Row r is rotated right by r positions: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*(4*((c - rw + 4) % 4) + rw) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
            r[119 - 32*c -: 8] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
            r[111 - 32*c -: 8] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
            r[103 - 32*c -: 8] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
        end
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox_pair.sv
// One AES S-box lane: forward (INVERSE=0, key schedule) or inverse (INVERSE=1, state path),
// built from GF(2^8) inversion as x^254 plus the affine map.
module aes_sbox_pair
    import aes_dec_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Addition chain 2,3,6,12,15,30,60,120,240 -> 240+12+2 = 254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    generate
        if (INVERSE) begin : g_inv
            logic [7:0] pre;
            assign pre        = rotl8(in_byte_i, 1) ^ rotl8(in_byte_i, 3) ^ rotl8(in_byte_i, 6) ^ 8'h05;
            assign out_byte_o = gf_inv(pre);
        end else begin : g_fwd
            logic [7:0] inv;
            assign inv        = gf_inv(in_byte_i);
            assign out_byte_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endgenerate

endmodule

// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to round 10, then one inverse round per clock.
// Optional last-key cache (skips key expansion on a repeated key): define AES_DEC_KEY_CACHE_EN.
module aes_128_dec_iter
    import aes_dec_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt,
    output logic         busy
);

    state_e       state_q;
    logic [127:0] st_q;
    logic [127:0] rk_q;
    logic [3:0]   cnt_q;
    logic [127:0] pt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [31:0]  w0, w1, w2, w3, w3_bwd;
    logic [31:0]  sub_in, sub_out, rcon_word;
    logic [3:0]   rcon_idx;
    logic [127:0] rk_fwd_d, rk_bwd_d;
    logic [127:0] isr, isb, ark, round_d;
    logic         cache_hit;
    logic [127:0] hit_rk10;

    assign {w0, w1, w2, w3} = rk_q;
    assign w3_bwd           = w3 ^ w2;

    // The four forward S-boxes are shared: KEXP needs SubWord(RotWord(w3)), ROUND needs it of w3^w2.
    assign sub_in    = (state_q == ROUND) ? rot_word(w3_bwd) : rot_word(w3);
    assign rcon_idx  = (state_q == ROUND) ? (cnt_q + 4'd1) : cnt_q;
    assign rcon_word = {rcon_lookup(rcon_idx), 24'h000000};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key_sbox
            aes_sbox_pair #(.INVERSE(1'b0)) u_sbox (
                .in_byte_i  (sub_in[8*gi +: 8]),
                .out_byte_o (sub_out[8*gi +: 8])
            );
        end
        for (gi = 0; gi < 16; gi++) begin : g_state_sbox
            aes_sbox_pair #(.INVERSE(1'b1)) u_sbox (
                .in_byte_i  (isr[8*gi +: 8]),
                .out_byte_o (isb[8*gi +: 8])
            );
        end
    endgenerate

    always_comb begin
        logic [31:0] f0, f1, f2, f3, b0;
        f0       = w0 ^ sub_out ^ rcon_word;
        f1       = w1 ^ f0;
        f2       = w2 ^ f1;
        f3       = w3 ^ f2;
        rk_fwd_d = {f0, f1, f2, f3};
        b0       = w0 ^ sub_out ^ rcon_word;
        rk_bwd_d = {b0, w1 ^ w0, w2 ^ w1, w3_bwd};
    end

    assign isr     = inv_shift_rows(st_q);
    assign ark     = isb ^ rk_bwd_d;
    assign round_d = (cnt_q == 4'd0) ? ark : inv_mix_columns(ark);

`ifdef AES_DEC_KEY_CACHE_EN
    logic         cache_valid_q;
    logic [127:0] cache_key_q;
    logic [127:0] cache_rk10_q;

    assign cache_hit = cache_valid_q && (key == cache_key_q);
    assign hit_rk10  = cache_rk10_q;

    // The key is latched at accept (entry invalid) and becomes usable once its round-10 key exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid_q <= 1'b0;
            cache_key_q   <= '0;
            cache_rk10_q  <= '0;
        end else if (state_q == IDLE && in_valid && in_ready_q && !cache_hit) begin
            cache_key_q   <= key;
            cache_valid_q <= 1'b0;
        end else if (state_q == KEXP && cnt_q == AES_NR) begin
            cache_rk10_q  <= rk_fwd_d;
            cache_valid_q <= 1'b1;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_rk10  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            st_q        <= '0;
            rk_q        <= '0;
            cnt_q       <= 4'd0;
            pt_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (cache_hit) begin
                            st_q    <= ct ^ hit_rk10;
                            rk_q    <= hit_rk10;
                            cnt_q   <= 4'd9;
                            state_q <= ROUND;
                        end else begin
                            st_q    <= ct;
                            rk_q    <= key;
                            cnt_q   <= 4'd1;
                            state_q <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    rk_q <= rk_fwd_d;
                    if (cnt_q == AES_NR) begin
                        st_q    <= st_q ^ rk_fwd_d;
                        cnt_q   <= 4'd9;
                        state_q <= ROUND;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                ROUND: begin
                    st_q <= round_d;
                    rk_q <= rk_bwd_d;
                    if (cnt_q == 4'd0) begin
                        pt_q        <= round_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign pt        = pt_q;
    assign busy      = busy_q;

endmodule
